// File: rtl/sp_ram_arb_pkg.sv
// Shared constants and types for the two-master single-port RAM arbiter.
package sp_ram_arb_pkg;

    localparam int   NUM_MASTERS  = 2;
    localparam logic MASTER_INSTR = 1'b0;
    localparam logic MASTER_DATA  = 1'b1;

    // State of the response that is one cycle behind its grant.
    typedef struct packed {
        logic owner;
        logic err;
        logic we;
        logic valid;
    } resp_t;

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-input round-robin grant logic. Purely combinational; the caller keeps
// the last-granted pointer and feeds it back in.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   last_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   idx_o
);

    // A lone requester wins outright; a tie goes to whoever did not win last.
    always_comb begin
        gnt_o = '0;
        idx_o = MASTER_INSTR;
        unique case (req_i)
            2'b01: begin
                gnt_o = 2'b01;
                idx_o = MASTER_INSTR;
            end
            2'b10: begin
                gnt_o = 2'b10;
                idx_o = MASTER_DATA;
            end
            2'b11: begin
                idx_o = ~last_i;
                gnt_o = last_i ? 2'b01 : 2'b10;
            end
            default: begin
                gnt_o = '0;
                idx_o = MASTER_INSTR;
            end
        endcase
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Front end for the single-port data/instruction RAM: arbitrates the fetch
// and LSU masters onto one port, filters out-of-range addresses, and steers
// the 1-cycle-latency read data back to the master that was granted.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_AW     = $clog2(RAM_SIZE)
) (
    input  logic                                     clk,
    input  logic                                     rstn_i,
    input  logic [NUM_MASTERS-1:0]                   m_req_i,
    output logic [NUM_MASTERS-1:0]                   m_gnt_o,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]                   m_we_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rdata_o,
    output logic [NUM_MASTERS-1:0]                   m_err_o,
    output logic                                     ram_en_o,
    output logic [RAM_AW-1:0]                        ram_addr_o,
    output logic [DATA_WIDTH-1:0]                    ram_wdata_o,
    output logic                                     ram_we_o,
    output logic [DATA_WIDTH/8-1:0]                  ram_be_o,
    input  logic [DATA_WIDTH-1:0]                    ram_rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;

    // One extra bit so a RAM as large as the address space still compares.
    localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(RAM_SIZE);

    logic [NUM_MASTERS-1:0] gnt;
    logic                   gidx;
    logic                   any_gnt;
    logic                   oor;

    logic rvalid_d, rvalid_q;
    logic owner_d,  owner_q;
    logic err_d,    err_q;
    logic we_d,     we_q;
    logic last_d,   last_q;

    resp_t resp;

    rr_arb2 u_arb (
        .req_i  (m_req_i),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gidx)
    );

    assign any_gnt = |gnt;
    assign m_gnt_o = gnt;

    // Drive the RAM port from the granted master; out-of-range accesses are
    // still granted but never enable the RAM.
    always_comb begin
        oor         = ({1'b0, m_addr_i[gidx]} >= RAM_LIMIT);
        ram_en_o    = any_gnt & ~oor;
        ram_addr_o  = m_addr_i[gidx][RAM_AW-1:0];
        ram_wdata_o = m_wdata_i[gidx];
        ram_we_o    = ram_en_o & m_we_i[gidx];
        ram_be_o    = ram_en_o ? m_be_i[gidx] : {BE_W{1'b0}};
    end

    // Capture who owns next cycle's response; idle cycles only drop valid.
    always_comb begin
        rvalid_d = any_gnt;
        owner_d  = owner_q;
        err_d    = err_q;
        we_d     = we_q;
        last_d   = last_q;
        if (any_gnt) begin
            owner_d = gidx;
            last_d  = gidx;
            err_d   = oor;
            we_d    = m_we_i[gidx];
        end
    end

    // Response state; reset discards any pending response and makes master 0
    // the winner of the first tie.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_q <= 1'b0;
            owner_q  <= MASTER_INSTR;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            last_q   <= MASTER_DATA;
        end else begin
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            we_q     <= we_d;
            last_q   <= last_d;
        end
    end

    // Steer the response to its owner; data is zero for writes, errors and
    // whenever no response is pending, so the lanes stay quiet in reset.
    always_comb begin
        resp       = '{owner: owner_q, err: err_q, we: we_q, valid: rvalid_q};
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        m_rvalid_o[resp.owner] = resp.valid;
        m_err_o[resp.owner]    = resp.valid & resp.err;
        if (resp.valid && !resp.we && !resp.err) begin
            m_rdata_o[resp.owner] = ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Randomised scoreboard bench for sp_ram_arbiter with a behavioural RAM.
module tb_sp_ram_arbiter;

    localparam int RAM_SIZE = 32768;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int RAW      = 15;
    localparam int BW       = 4;

    logic                   clk;
    logic                   rstn_i;
    logic [1:0]             m_req_i;
    logic [1:0]             m_gnt_o;
    logic [1:0][AW-1:0]     m_addr_i;
    logic [1:0]             m_we_i;
    logic [1:0][BW-1:0]     m_be_i;
    logic [1:0][DW-1:0]     m_wdata_i;
    logic [1:0]             m_rvalid_o;
    logic [1:0][DW-1:0]     m_rdata_o;
    logic [1:0]             m_err_o;
    logic                   ram_en_o;
    logic [RAW-1:0]         ram_addr_o;
    logic [DW-1:0]          ram_wdata_o;
    logic                   ram_we_o;
    logic [BW-1:0]          ram_be_o;
    logic [DW-1:0]          ram_rdata_i;

    sp_ram_arbiter #(
        .RAM_SIZE   (RAM_SIZE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_AW     (RAW)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .m_req_i     (m_req_i),
        .m_gnt_o     (m_gnt_o),
        .m_addr_i    (m_addr_i),
        .m_we_i      (m_we_i),
        .m_be_i      (m_be_i),
        .m_wdata_i   (m_wdata_i),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .m_err_o     (m_err_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    logic [DW-1:0] ram_mem [0:(RAM_SIZE/4)-1];
    initial begin
        for (int i = 0; i < RAM_SIZE / 4; i++) ram_mem[i] = '0;
        ram_rdata_i = '0;
    end
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be_o[b]) ram_mem[ram_addr_o[RAW-1:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o[RAW-1:2]];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        int          lane;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] ref_mem [int];
    logic        ref_last = 1'b1;
    logic        prev_gnt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One bus cycle: drive, check the combinational grant/RAM side against the
    // model, and queue the response the model expects one cycle later.
    task automatic step(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] we, input logic [3:0] be0, input logic [3:0] be1,
                        input logic [31:0] w0, input logic [31:0] w1);
        int          g;
        int          key;
        logic        oor;
        logic        wv;
        logic [31:0] ad, wd, cur;
        logic [3:0]  bv;
        exp_t        e;
        @(posedge clk);
        #1;
        m_req_i      = req;
        m_addr_i[0]  = a0;
        m_addr_i[1]  = a1;
        m_we_i       = we;
        m_be_i[0]    = be0;
        m_be_i[1]    = be1;
        m_wdata_i[0] = w0;
        m_wdata_i[1] = w1;
        #1;
        if (!prev_gnt) check("rvalid_after_idle", m_rvalid_o, 0);
        case (req)
            2'b01:   g = 0;
            2'b10:   g = 1;
            2'b11:   g = ref_last ? 0 : 1;
            default: g = -1;
        endcase
        if (g < 0) begin
            check("gnt_idle", m_gnt_o, 0);
            check("ram_en_idle", ram_en_o, 0);
            check("ram_we_idle", ram_we_o, 0);
            check("ram_be_idle", ram_be_o, 0);
        end else begin
            ad  = (g == 1) ? a1 : a0;
            wd  = (g == 1) ? w1 : w0;
            bv  = (g == 1) ? be1 : be0;
            wv  = we[g];
            oor = (ad >= RAM_SIZE);
            check("gnt", m_gnt_o, 32'(1) << g);
            check("ram_en", ram_en_o, !oor);
            if (!oor) begin
                check("ram_addr", ram_addr_o, ad % RAM_SIZE);
                check("ram_we", ram_we_o, wv);
                check("ram_be", ram_be_o, bv);
                check("ram_wdata", ram_wdata_o, wd);
            end else begin
                check("ram_we_oor", ram_we_o, 0);
                check("ram_be_oor", ram_be_o, 0);
            end
            key = int'((ad % RAM_SIZE) / 4);
            cur = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            e.stamp = cyc;
            e.lane  = g;
            e.err   = oor;
            e.rdata = (wv || oor) ? 32'h0 : cur;
            sbq.push_back(e);
            if (wv && !oor) begin
                for (int b = 0; b < 4; b++)
                    if (bv[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
                ref_mem[key] = cur;
            end
            ref_last = (g == 1);
        end
        prev_gnt = (g >= 0);
    endtask

    task automatic idle();
        step(2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle; any queued response is lost with it.
    task automatic do_reset();
        rstn_i  = 1'b0;
        m_req_i = 2'b00;
        sbq.delete();
        #1;
        check("rst_rvalid", m_rvalid_o, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid_hold", m_rvalid_o, 0);
        check("rst_err", m_err_o, 0);
        check("rst_rdata0", m_rdata_o[0], 0);
        check("rst_rdata1", m_rdata_o[1], 0);
        rstn_i   = 1'b1;
        ref_last = 1'b1;
        prev_gnt = 1'b0;
    endtask

    // Response monitor: every rvalid must match the oldest queued expectation
    // exactly one cycle after its grant.
    always @(negedge clk) begin
        exp_t e;
        if (m_rvalid_o != 2'b00) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual=%b required=00", m_rvalid_o);
            end else begin
                e = sbq.pop_front();
                check("resp_cycle", cyc, e.stamp + 1);
                check("rvalid", m_rvalid_o, 32'(1) << e.lane);
                check("err", m_err_o, 32'(e.err) << e.lane);
                check("rdata", m_rdata_o[e.lane], e.rdata);
                check("rdata_other", m_rdata_o[1 - e.lane], 0);
            end
        end else if (sbq.size() > 0 && sbq[0].stamp < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_rvalid actual=%b required=%0d", m_rvalid_o, sbq[0].lane);
            void'(sbq.pop_front());
        end
    end

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000 + 32'($urandom_range(0, 255)) * 4;
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rstn_i    = 1'b0;
        m_req_i   = '0;
        m_addr_i  = '0;
        m_we_i    = '0;
        m_be_i    = '0;
        m_wdata_i = '0;
        do_reset();

        // Continuous contention straight out of reset alternates 0,1,0,1,...
        for (int i = 0; i < 6; i++)
            step(2'b11, 32'h40, 32'h80, 2'b00, 4'hF, 4'hF, 0, 0);
        idle();

        // Write then immediate read of the same word by the data master.
        step(2'b10, 0, 32'h100, 2'b10, 0, 4'hF, 0, 32'hDEADBEEF);
        step(2'b10, 0, 32'h100, 2'b00, 0, 4'hF, 0, 0);
        idle();

        // Byte write merges into an existing word.
        step(2'b10, 0, 32'h200, 2'b10, 0, 4'hF, 0, 32'h11223344);
        idle();
        step(2'b10, 0, 32'h200, 2'b10, 0, 4'b0001, 0, 32'h000000AA);
        step(2'b01, 32'h200, 0, 2'b00, 4'hF, 0, 0, 0);
        idle();

        // First byte past the RAM and the last word inside it.
        step(2'b01, 32'h8000, 0, 2'b00, 4'hF, 0, 0, 0);
        step(2'b01, 32'h7FFC, 0, 2'b01, 4'hF, 0, 32'hCAFEF00D, 0);
        step(2'b10, 0, 32'h7FFC, 2'b00, 0, 4'hF, 0, 0);
        idle();

        // Reset between a read grant and its response.
        step(2'b01, 32'h100, 0, 2'b00, 4'hF, 0, 0, 0);
        do_reset();
        step(2'b11, 32'h100, 32'h200, 2'b00, 4'hF, 4'hF, 0, 0);
        idle();
        idle();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        idle();
        idle();
        check("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
